// File: rtl/jtframe_dump_pkg.sv
// Shared state encoding for the frame counter / capture trigger.
package jtframe_dump_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        COUNT = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } dump_st_t;

endpackage

// File: rtl/jtframe_edge.sv
// Registered edge detector: remembers the previous sample of din and flags
// rising and falling transitions against the current input value.
module jtframe_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall,
    output logic rise
);

    logic din_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_l <= 1'b0;
        else     din_l <= din;
    end

    assign fall = din_l & ~din;
    assign rise = ~din_l & din;

endmodule

// File: rtl/jtframe_dump_trigger.sv
// Frame counter and capture-window trigger driven by vertical sync and the
// ROM download flag. All outputs are registered.
module jtframe_dump_trigger
    import jtframe_dump_pkg::*;
#(
    parameter int CW      = 32,
    parameter int START   = 0,
    parameter int LEN     = 0,
    parameter bit WAIT_DL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs,
    input  logic          downloading,
    output logic [CW-1:0] frame_cnt,
    output logic          dump_on,
    output logic          dump_start,
    output logic          dump_stop,
    output logic [1:0]    st
);

    localparam logic [CW-1:0] START_C = CW'(START);
    localparam logic [CW-1:0] STOP_C  = START_C + CW'(LEN);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam dump_st_t      RST_ST  = WAIT_DL ? WAIT : COUNT;

    logic     vs_fall, vs_rise_unused;
    logic     dl_fall, dl_rise;
    dump_st_t state;

    jtframe_edge u_vs_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (vs),
        .fall (vs_fall),
        .rise (vs_rise_unused)
    );

    jtframe_edge u_dl_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (downloading),
        .fall (dl_fall),
        .rise (dl_rise)
    );

    assign st = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RST_ST;
            frame_cnt  <= '0;
            dump_on    <= 1'b0;
            dump_start <= 1'b0;
            dump_stop  <= 1'b0;
        end else begin
            dump_start <= 1'b0;
            dump_stop  <= 1'b0;
            // A new download restarts everything and beats a same-cycle vs fall.
            if (dl_rise && state != WAIT) begin
                state     <= WAIT;
                frame_cnt <= '0;
                dump_on   <= 1'b0;
                dump_stop <= (state == DUMP);
            end else begin
                case (state)
                    WAIT: begin
                        frame_cnt <= '0;
                        if (dl_fall) state <= COUNT;
                    end
                    COUNT: if (vs_fall) begin
                        frame_cnt <= frame_cnt + ONE;
                        if (frame_cnt == START_C) begin
                            state      <= DUMP;
                            dump_on    <= 1'b1;
                            dump_start <= 1'b1;
                        end
                    end
                    DUMP: if (vs_fall) begin
                        frame_cnt <= frame_cnt + ONE;
                        // LEN of zero leaves the window open forever.
                        if (LEN != 0 && frame_cnt == STOP_C) begin
                            state     <= DONE;
                            dump_on   <= 1'b0;
                            dump_stop <= 1'b1;
                        end
                    end
                    DONE: if (vs_fall) frame_cnt <= frame_cnt + ONE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_dump_trigger.sv
// Bench for jtframe_dump_trigger: three parameterisations share one stimulus
// stream and are checked every cycle against an event-level model.
module tb_jtframe_dump_trigger;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vs = 1'b0;
    logic downloading = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] fc_a;
    logic [7:0]  fc_b;
    logic [3:0]  fc_c;
    logic [2:0]  on_w, start_w, stop_w;
    logic [1:0]  st_a, st_b, st_c;

    jtframe_dump_trigger #(.CW(32), .START(3), .LEN(2), .WAIT_DL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .frame_cnt(fc_a), .dump_on(on_w[0]), .dump_start(start_w[0]),
        .dump_stop(stop_w[0]), .st(st_a)
    );

    jtframe_dump_trigger #(.CW(8), .START(1), .LEN(0), .WAIT_DL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .frame_cnt(fc_b), .dump_on(on_w[1]), .dump_start(start_w[1]),
        .dump_stop(stop_w[1]), .st(st_b)
    );

    jtframe_dump_trigger #(.CW(4), .START(15), .LEN(3), .WAIT_DL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .frame_cnt(fc_c), .dump_on(on_w[2]), .dump_start(start_w[2]),
        .dump_stop(stop_w[2]), .st(st_c)
    );

    int total = 0;
    int bad = 0;

    // Model: per instance, whether frames are being counted, the running
    // count, and whether the window has opened / closed since last restart.
    longint m_mod[3];
    longint m_start[3];
    longint m_len[3];
    bit     m_wdl[3];
    bit     m_counting[3];
    bit     m_open[3];
    bit     m_closed[3];
    longint m_cnt[3];
    bit     e_start[3];
    bit     e_stop[3];
    bit     prev_vs, prev_dl;

    int fall_idx = 0;
    int start_at = 0;
    int stop_at = 0;
    int b_stops = 0;
    bit a_on_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_counting[k] = !m_wdl[k];
            m_open[k] = 1'b0;
            m_closed[k] = 1'b0;
            m_cnt[k] = 0;
            e_start[k] = 1'b0;
            e_stop[k] = 1'b0;
        end
        prev_vs = 1'b0;
        prev_dl = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit d);
        bit vf, dr, df;
        vf = prev_vs && !v;
        dr = !prev_dl && d;
        df = prev_dl && !d;
        if (vf) fall_idx++;
        for (int k = 0; k < 3; k++) begin
            e_start[k] = 1'b0;
            e_stop[k] = 1'b0;
            if (!m_counting[k]) begin
                if (df) m_counting[k] = 1'b1;
            end else if (dr) begin
                e_stop[k] = m_open[k] && !m_closed[k];
                m_counting[k] = 1'b0;
                m_cnt[k] = 0;
                m_open[k] = 1'b0;
                m_closed[k] = 1'b0;
            end else if (vf) begin
                if (!m_open[k] && m_cnt[k] == m_start[k]) begin
                    m_open[k] = 1'b1;
                    e_start[k] = 1'b1;
                end else if (m_open[k] && !m_closed[k] && m_len[k] != 0 &&
                             m_cnt[k] == (m_start[k] + m_len[k]) % m_mod[k]) begin
                    m_closed[k] = 1'b1;
                    e_stop[k] = 1'b1;
                end
                m_cnt[k] = (m_cnt[k] + 1) % m_mod[k];
            end
        end
        prev_vs = v;
        prev_dl = d;
    endtask

    function automatic logic [31:0] exp_st(input int k);
        if (!m_counting[k]) return 32'd0;
        if (!m_open[k])     return 32'd1;
        if (!m_closed[k])   return 32'd2;
        return 32'd3;
    endfunction

    task automatic check_all();
        logic [31:0] o_fc[3];
        logic [31:0] o_st[3];
        o_fc[0] = fc_a;
        o_fc[1] = {24'b0, fc_b};
        o_fc[2] = {28'b0, fc_c};
        o_st[0] = {30'b0, st_a};
        o_st[1] = {30'b0, st_b};
        o_st[2] = {30'b0, st_c};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cnt%0d", k), o_fc[k], 32'(m_cnt[k]));
            chk($sformatf("st%0d", k), o_st[k], exp_st(k));
            chk($sformatf("on%0d", k), {31'b0, on_w[k]},
                {31'b0, m_counting[k] && m_open[k] && !m_closed[k]});
            chk($sformatf("start%0d", k), {31'b0, start_w[k]}, {31'b0, e_start[k]});
            chk($sformatf("stop%0d", k), {31'b0, stop_w[k]}, {31'b0, e_stop[k]});
        end
        if (start_w[0]) start_at = fall_idx;
        if (stop_w[0])  stop_at = fall_idx;
        if (stop_w[1])  b_stops++;
        if (on_w[0])    a_on_seen = 1'b1;
    endtask

    // Called at a falling clock edge: drive, let one rising edge pass, check.
    task automatic cyc(input bit v, input bit d);
        vs = v;
        downloading = d;
        model_step(v, d);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic vs_pulse(input int hi, input int lo);
        repeat (hi) cyc(1'b1, 1'b0);
        repeat (lo) cyc(1'b0, 1'b0);
    endtask

    task automatic dl_pulse(input int len);
        repeat (len) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    task automatic rand_frames(input int n);
        for (int i = 0; i < n; i++)
            vs_pulse($urandom_range(1, 3), $urandom_range(1, 3));
    endtask

    initial begin
        m_mod[0] = 64'd4294967296; m_start[0] = 3;  m_len[0] = 2; m_wdl[0] = 1'b1;
        m_mod[1] = 64'd256;        m_start[1] = 1;  m_len[1] = 0; m_wdl[1] = 1'b0;
        m_mod[2] = 64'd16;         m_start[2] = 15; m_len[2] = 3; m_wdl[2] = 1'b0;
        model_reset();

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // No download yet: instance A must stay idle
        rand_frames(5);
        chk("a_idle_cnt", fc_a, 32'd0);
        chk("a_idle_on", {31'b0, a_on_seen}, 32'd0);

        // Download whose end coincides with a vs fall: no increment
        repeat (3) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("a_simul_cnt", fc_a, 32'd0);
        chk("a_simul_st", {30'b0, st_a}, 32'd1);

        // Eight frames: window opens at 4th fall, closes at 6th
        fall_idx = 0;
        start_at = 0;
        stop_at = 0;
        rand_frames(8);
        chk("a_start_at", 32'(start_at), 32'd4);
        chk("a_stop_at", 32'(stop_at), 32'd6);
        chk("a_final_cnt", fc_a, 32'd8);
        chk("a_final_st", {30'b0, st_a}, 32'd3);

        // Randomized mix of frames, downloads and long vs holds
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: begin
                    repeat ($urandom_range(1, 3)) cyc(1'($urandom_range(0, 1)), 1'b1);
                    cyc(1'($urandom_range(0, 1)), 1'b0);
                end
                1: vs_pulse($urandom_range(8, 15), $urandom_range(8, 15));
                default: vs_pulse($urandom_range(1, 4), $urandom_range(1, 4));
            endcase
        end

        // Wrap in the 4-bit instance, endless window in the LEN=0 instance
        dl_pulse(2);
        b_stops = 0;
        rand_frames(20);
        chk("c_wrap_cnt", {28'b0, fc_c}, 32'd4);
        chk("c_wrap_st", {30'b0, st_c}, 32'd3);
        chk("a_20_cnt", fc_a, 32'd20);
        rand_frames(80);
        chk("b_100_cnt", {24'b0, fc_b}, 32'd100);
        chk("b_100_on", {31'b0, on_w[1]}, 32'd1);
        chk("b_no_stop", 32'(b_stops), 32'd0);

        // Download rising together with a vs fall while A is dumping
        dl_pulse(2);
        rand_frames(4);
        chk("a_in_dump", {30'b0, st_a}, 32'd2);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        chk("a_abort_stop", {31'b0, stop_w[0]}, 32'd1);
        chk("a_abort_cnt", fc_a, 32'd0);
        chk("a_abort_st", {30'b0, st_a}, 32'd0);
        cyc(1'b0, 1'b0);
        fall_idx = 0;
        start_at = 0;
        rand_frames(4);
        chk("a_reopen_at", 32'(start_at), 32'd4);
        chk("a_reopen_st", {30'b0, st_a}, 32'd2);

        // Asynchronous reset between clock edges during DUMP
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_a_on", {31'b0, on_w[0]}, 32'd0);
        chk("rst_a_cnt", fc_a, 32'd0);
        chk("rst_a_st", {30'b0, st_a}, 32'd0);
        chk("rst_a_stop", {31'b0, stop_w[0]}, 32'd0);
        chk("rst_c_st", {30'b0, st_c}, 32'd1);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        rand_frames(6);
        dl_pulse(1);
        rand_frames(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
